unified_mem_arbiter: RTL and testbench

//  Shares one single-port, variable-latency memory between the IF stage (instruction fetch, read-only)
//  and the MEM stage (LW/SW, driven by the decoder's MemRead/MemWrite) of the 5-stage MIPS pipeline.

---
 rtl/unified_mem_arbiter_pkg.sv | 13 +
 rtl/mem_timeout_counter.sv | 28 ++
 rtl/unified_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared arbiter definitions: FSM state encoding and the data returned on a timed-out access.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    IF_BUSY  = 2'd1,
    DM_BUSY  = 2'd2,
    RESP     = 2'd3
  } arb_state_e;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_timeout_counter.sv
// Busy-cycle counter for the memory arbiter; tc flags the last cycle before an access is abandoned.
module mem_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign tc = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port variable-latency memory between instruction fetch and the data stage.
// Data side has priority; IF is forced after STREAK_MAX data grants; stuck accesses time out.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              bus_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int SW = $clog2(STREAK_MAX + 1);

  arb_state_e        state, state_next;
  logic [SW-1:0]     streak;
  logic              dm_req, force_if, grant_dm, grant_if;
  logic              busy, tc, done;
  logic [DATA_W-1:0] resp_data;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

  assign dm_req   = dm_read | dm_write;
  assign force_if = if_req && (streak == SW'(STREAK_MAX));
  assign busy     = (state == IF_BUSY) || (state == DM_BUSY);
  assign done     = busy && (mem_ack || tc);
  // Ack beats a simultaneous timeout; writes never return memory data.
  assign resp_data = !mem_ack ? DATA_W'(ARB_ERR_DATA) : (mem_we ? '0 : mem_rdata);

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!busy),
    .enable (busy),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (dm_req && !force_if) begin
          grant_dm   = 1'b1;
          state_next = DM_BUSY;
        end else if (if_req) begin
          grant_if   = 1'b1;
          state_next = IF_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (done) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = ARB_IDLE;
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (state == ARB_IDLE) begin
      if (!if_req || grant_if) begin
        streak <= '0;
      end else if (grant_dm && (streak != SW'(STREAK_MAX))) begin
        streak <= streak + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_ready  <= 1'b0;
      dm_rdata  <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (grant_dm || grant_if) begin
        mem_en    <= 1'b1;
        mem_we    <= grant_dm && dm_write;
        mem_addr  <= grant_dm ? dm_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
        mem_wdata <= grant_dm ? dm_wdata : '0;
      end
      if (done) begin
        mem_en  <= 1'b0;
        bus_err <= !mem_ack;
        if (state == IF_BUSY) begin
          if_ready <= 1'b1;
          if_rdata <= resp_data;
        end else begin
          dm_ready <= 1'b1;
          dm_rdata <= resp_data;
        end
      end
      if (state == RESP) begin
        if_ready <= 1'b0;
        if_rdata <= '0;
        dm_ready <= 1'b0;
        dm_rdata <= '0;
        bus_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: requesters push expectations, a monitor checks grants and responses.
module tb_unified_mem_arbiter;

  localparam int STREAK_MAX = 2;
  localparam int TIMEOUT    = 64;

  logic        clk, rst_n;
  logic        if_req, dm_read, dm_write;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, bus_err, mem_en, mem_we, mem_ack;
  logic [29:0] mem_addr;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STREAK_MAX(STREAK_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .bus_err(bus_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] word;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          len;
  } exp_t;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  logic [31:0] mem_arr [logic [29:0]];
  logic [31:0] ref_b   [logic [29:0]];
  int          total = 0;
  int          bad = 0;
  int          ack_mode = 0;   // 0 random delay, 1 never ack, 2 fixed delay
  int          ack_fixed = 0;
  int          ack_max = 3;
  int          streak_m = 0;

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return (32'h9E37_79B9 * {2'b00, a}) + 32'h1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none at %0t", name, $time);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({mem_en, mem_we, if_ready, dm_ready, bus_err}), 32'h0);
    chk({tag, "_mem_addr"}, {2'b00, mem_addr}, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
  endtask

  // Memory model: acks after a chosen delay, stores writes, drives garbage when not acking.
  int wait_left = 0;
  bit in_acc = 0;
  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (!rst_n || !mem_en) begin
      in_acc = 0;
    end else begin
      if (!in_acc) begin
        in_acc    = 1;
        wait_left = (ack_mode == 2) ? ack_fixed : int'($urandom_range(ack_max, 0));
      end else if (wait_left > 0) begin
        wait_left--;
      end
      if (ack_mode != 1 && wait_left == 0) begin
        mem_ack = 1'b1;
        in_acc  = 0;
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        else mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_word(mem_addr);
      end
    end
  end

  logic if_req_q = 1'b0;
  logic dm_req_q = 1'b0;
  always @(posedge clk) begin
    if_req_q <= if_req;
    dm_req_q <= dm_read | dm_write;
  end

  logic        en_prev = 1'b0;
  int          en_cnt = 0;
  logic [29:0] cap_addr;
  logic        cap_we;
  logic [31:0] cap_wdata;
  logic        want_dm;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev = 1'b0;
      en_cnt  = 0;
    end else begin
      if (mem_en && !en_prev) begin
        want_dm = dm_req_q && !(if_req_q && streak_m == STREAK_MAX);
        if (!dm_req_q && !if_req_q) begin
          fail_now("grant_without_request");
        end else if (want_dm ? (dm_q.size() == 0) : (if_q.size() == 0)) begin
          fail_now("grant_no_pending_entry");
        end else begin
          e = want_dm ? dm_q[0] : if_q[0];
          chk("grant_addr", {2'b00, mem_addr}, {2'b00, e.word});
          chk("grant_we", 32'(mem_we), 32'(e.we));
          if (e.we) chk("grant_wdata", mem_wdata, e.wdata);
        end
        if (!want_dm) streak_m = 0;
        else if (!if_req_q) streak_m = 0;
        else if (streak_m < STREAK_MAX) streak_m++;
        cap_addr  = mem_addr;
        cap_we    = mem_we;
        cap_wdata = mem_wdata;
        en_cnt    = 1;
      end else if (mem_en) begin
        en_cnt++;
        chk("hold_addr_we", {1'b0, cap_we, cap_addr}, {1'b0, mem_we, mem_addr});
        chk("hold_wdata", mem_wdata, cap_wdata);
      end
      en_prev = mem_en;

      if (if_ready) begin
        if (if_q.size() == 0) begin
          fail_now("unexpected_if_ready");
        end else begin
          e = if_q.pop_front();
          chk("if_rdata", if_rdata, e.rdata);
          chk("if_bus_err", 32'(bus_err), 32'(e.err));
          chk("if_other_ready", 32'(dm_ready), 32'h0);
          chk("if_resp_mem_en", 32'(mem_en), 32'h0);
          if (e.len >= 0) chk("if_en_cycles", en_cnt, e.len);
        end
      end else begin
        chk("if_rdata_idle", if_rdata, 32'h0);
      end

      if (dm_ready) begin
        if (dm_q.size() == 0) begin
          fail_now("unexpected_dm_ready");
        end else begin
          e = dm_q.pop_front();
          chk("dm_rdata", dm_rdata, e.rdata);
          chk("dm_bus_err", 32'(bus_err), 32'(e.err));
          chk("dm_resp_mem_en", 32'(mem_en), 32'h0);
          if (e.len >= 0) chk("dm_en_cycles", en_cnt, e.len);
        end
      end else begin
        chk("dm_rdata_idle", dm_rdata, 32'h0);
      end

      if (!if_ready && !dm_ready) chk("bus_err_idle", 32'(bus_err), 32'h0);
    end
  end

  task automatic if_access(input logic [31:0] addr, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_len);
    exp_t x;
    int   n;
    x.word = addr[31:2]; x.we = 1'b0; x.wdata = '0;
    x.rdata = exp_rdata; x.err = exp_err; x.len = exp_len;
    if_q.push_back(x);
    if_req  = 1'b1;
    if_addr = addr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_ready && n < 400);
    if (!if_ready) begin
      fail_now("if_ready_wait_expired");
      if_q.delete();
    end
    if_req = 1'b0;
  endtask

  task automatic dm_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_len);
    exp_t x;
    int   n;
    x.word = addr[31:2]; x.we = wr; x.wdata = wdata;
    x.rdata = exp_rdata; x.err = exp_err; x.len = exp_len;
    dm_q.push_back(x);
    dm_read  = rd;
    dm_write = wr;
    dm_addr  = addr;
    dm_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dm_ready && n < 400);
    if (!dm_ready) begin
      fail_now("dm_ready_wait_expired");
      dm_q.delete();
    end
    dm_read  = 1'b0;
    dm_write = 1'b0;
  endtask

  task automatic if_loop(input int n, input int idle_max);
    for (int i = 0; i < n; i++) begin
      logic [29:0] w;
      repeat ($urandom_range(idle_max, 0)) @(negedge clk);
      w = 30'h0010_0400 + 30'($urandom_range(255, 0));
      if_access({w, 2'b00}, init_word(w), 1'b0, -1);
    end
  endtask

  task automatic dm_loop(input int n, input int idle_max);
    for (int i = 0; i < n; i++) begin
      logic [29:0] w;
      logic [31:0] wd, ex;
      int          op;
      repeat ($urandom_range(idle_max, 0)) @(negedge clk);
      w  = 30'h0400_0000 + 30'($urandom_range(63, 0));
      op = int'($urandom_range(2, 0));
      wd = $urandom;
      if (op == 0) begin
        ex = ref_b.exists(w) ? ref_b[w] : init_word(w);
      end else begin
        ref_b[w] = wd;
        ex = 32'h0;
      end
      dm_access(op != 1, op != 0, {w, 2'b00}, wd, ex, 1'b0, -1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_read = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_arr[30'h0010_0004] = 32'h2408_0005;
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single fetch, ack three cycles after mem_en
    ack_mode = 2; ack_fixed = 3;
    if_access(32'h0040_0010, 32'h2408_0005, 1'b0, 4);

    // store, then load it back
    ack_fixed = 1;
    ref_b[30'h0400_0002] = 32'hCAFE_F00D;
    dm_access(1'b0, 1'b1, 32'h1000_0008, 32'hCAFE_F00D, 32'h0, 1'b0, 2);
    dm_access(1'b1, 1'b0, 32'h1000_0008, 32'h0, 32'hCAFE_F00D, 1'b0, 2);

    // unresponsive memory on both ports
    ack_mode = 1;
    dm_access(1'b1, 1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 1'b1, TIMEOUT);
    if_access(32'h0040_2000, 32'hDEAD_BEEF, 1'b1, TIMEOUT);

    // ack on the terminal timeout cycle, and one cycle before it
    ack_mode = 2; ack_fixed = TIMEOUT - 1;
    dm_access(1'b1, 1'b0, 32'h1000_0014, 32'h0, init_word(30'h0400_0005), 1'b0, TIMEOUT);
    ack_fixed = TIMEOUT - 2;
    dm_access(1'b1, 1'b0, 32'h1000_0018, 32'h0, init_word(30'h0400_0006), 1'b0, TIMEOUT - 1);

    // concurrent random traffic, then saturated traffic for the starvation bound
    ack_mode = 0; ack_max = 3;
    fork
      if_loop(40, 2);
      dm_loop(60, 2);
    join
    ack_max = 0;
    fork
      if_loop(30, 0);
      dm_loop(70, 0);
    join

    // reset in the middle of a data access
    ack_mode = 1;
    begin
      exp_t x;
      x.word = 30'h0400_0008; x.we = 1'b0; x.wdata = '0;
      x.rdata = 32'h0; x.err = 1'b0; x.len = -1;
      dm_q.push_back(x);
    end
    dm_read = 1'b1; dm_addr = 32'h1000_0020;
    repeat (4) @(negedge clk);
    chk("mid_busy_mem_en", 32'(mem_en), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    dm_read = 1'b0;
    dm_q.delete();
    if_q.delete();
    streak_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_mem_en", 32'(mem_en), 32'h0);
    ack_mode = 0; ack_max = 2;
    dm_access(1'b1, 1'b0, 32'h1000_0020, 32'h0,
              ref_b.exists(30'h0400_0008) ? ref_b[30'h0400_0008] : init_word(30'h0400_0008),
              1'b0, -1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
